// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding a start/data/parity/stop serialiser.
// Frame settings are captured when a byte leaves the FIFO, so the frame in flight
// is unaffected by later configuration changes.
module uart_tx_buffered #(
   parameter  int unsigned FIFO_DEPTH = 16,
   parameter  int unsigned DIV_WIDTH  = 16,
   localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 s_axi_aclk,
   input  logic                 s_axi_aresetn,
   input  logic [7:0]           tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic [DIV_WIDTH-1:0] divisor,
   input  logic [1:0]           data_size,
   input  logic                 parity_en,
   input  logic                 parity_mode,
   input  logic                 stop_bits,
   input  logic                 buf_clear,
   input  logic [CNT_W-1:0]     irq_threshold,
   output logic                 tx,
   output logic                 busy,
   output logic [CNT_W-1:0]     fill_level,
   output logic                 empty,
   output logic                 full,
   output logic                 interrupt
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   logic [7:0]           mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [CNT_W-1:0]     count_nxt_c;

   state_t               state;
   logic [DIV_WIDTH-1:0] baud_cnt;
   logic [DIV_WIDTH-1:0] div_l;
   logic [7:0]           shreg;
   logic [2:0]           bit_idx;
   logic [2:0]           last_idx;
   logic                 par_en_l;
   logic                 par_bit;
   logic                 stop2_l;
   logic                 stop_idx;

   logic                 push_c;
   logic                 pop_c;
   logic                 bit_end_c;
   logic                 frame_end_c;
   logic [7:0]           mask_c;
   logic [7:0]           data_c;
   logic                 line_c;

   // Handshake, bit timing and FIFO head decode
   always_comb begin
      push_c      = tx_valid && !full && !buf_clear;
      bit_end_c   = (baud_cnt == div_l);
      frame_end_c = (state == STOP) && bit_end_c && (stop_idx || !stop2_l);
      pop_c       = ((state == IDLE) || frame_end_c) && !empty && !buf_clear;
      mask_c      = 8'hFF >> (2'd3 - data_size);
      data_c      = mem[rd_ptr] & mask_c;
   end

   // Next fill level; a clear wins over any same-edge push or pop
   always_comb begin
      count_nxt_c = fill_level;
      if (buf_clear) begin
         count_nxt_c = '0;
      end else if (push_c && !pop_c) begin
         count_nxt_c = fill_level + CNT_W'(1);
      end else if (pop_c && !push_c) begin
         count_nxt_c = fill_level - CNT_W'(1);
      end
   end

   // Serial line level for the current state, registered into tx one edge later
   always_comb begin
      line_c = 1'b1;
      case (state)
         START:   line_c = 1'b0;
         DATA:    line_c = shreg[0];
         PARITY:  line_c = par_bit;
         default: line_c = 1'b1;
      endcase
   end

   // FIFO storage, no reset needed on the data array
   always_ff @(posedge s_axi_aclk) begin
      if (push_c) begin
         mem[wr_ptr] <= tx_data;
      end
   end

   // FIFO pointers and registered status flags
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_level <= '0;
         empty      <= 1'b1;
         full       <= 1'b0;
         tx_ready   <= 1'b1;
      end else begin
         if (buf_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
         end
         fill_level <= count_nxt_c;
         empty      <= (count_nxt_c == '0);
         full       <= (count_nxt_c == CNT_W'(FIFO_DEPTH));
         tx_ready   <= (count_nxt_c != CNT_W'(FIFO_DEPTH));
      end
   end

   // Frame sequencer with latched per-frame configuration and registered outputs
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         div_l     <= '0;
         shreg     <= '0;
         bit_idx   <= '0;
         last_idx  <= '0;
         par_en_l  <= 1'b0;
         par_bit   <= 1'b0;
         stop2_l   <= 1'b0;
         stop_idx  <= 1'b0;
         tx        <= 1'b1;
         busy      <= 1'b0;
         interrupt <= 1'b0;
      end else begin
         tx        <= line_c;
         busy      <= (state != IDLE);
         interrupt <= frame_end_c && (fill_level <= irq_threshold);
         if (pop_c) begin
            state    <= START;
            baud_cnt <= '0;
            div_l    <= divisor;
            shreg    <= data_c;
            last_idx <= 3'(data_size) + 3'd4;
            par_en_l <= parity_en;
            par_bit  <= (^data_c) ^ parity_mode;
            stop2_l  <= stop_bits;
         end else if (frame_end_c) begin
            state    <= IDLE;
            baud_cnt <= '0;
         end else if (state != IDLE) begin
            if (!bit_end_c) begin
               baud_cnt <= baud_cnt + DIV_WIDTH'(1);
            end else begin
               baud_cnt <= '0;
               case (state)
                  START: begin
                     state   <= DATA;
                     bit_idx <= '0;
                  end
                  DATA: begin
                     shreg <= {1'b0, shreg[7:1]};
                     if (bit_idx == last_idx) begin
                        state    <= par_en_l ? PARITY : STOP;
                        stop_idx <= 1'b0;
                     end else begin
                        bit_idx <= bit_idx + 3'd1;
                     end
                  end
                  PARITY: begin
                     state    <= STOP;
                     stop_idx <= 1'b0;
                  end
                  STOP:    stop_idx <= 1'b1;
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed self-checking bench for uart_tx_buffered.
module tb_uart_tx_buffered;

   localparam int unsigned CW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    tx_data = '0;
   logic          tx_valid = 1'b0;
   logic          tx_ready;
   logic [15:0]   divisor = 16'd9;
   logic [1:0]    data_size = 2'd3;
   logic          parity_en = 1'b0;
   logic          parity_mode = 1'b0;
   logic          stop_bits = 1'b0;
   logic          buf_clear = 1'b0;
   logic [CW-1:0] irq_threshold = '0;
   logic          tx;
   logic          busy;
   logic [CW-1:0] fill_level;
   logic          empty;
   logic          full;
   logic          interrupt;

   int checks = 0;
   int failures = 0;

   uart_tx_buffered #(.FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
      .s_axi_aclk    (clk),
      .s_axi_aresetn (rst_n),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .divisor       (divisor),
      .data_size     (data_size),
      .parity_en     (parity_en),
      .parity_mode   (parity_mode),
      .stop_bits     (stop_bits),
      .buf_clear     (buf_clear),
      .irq_threshold (irq_threshold),
      .tx            (tx),
      .busy          (busy),
      .fill_level    (fill_level),
      .empty         (empty),
      .full          (full),
      .interrupt     (interrupt)
   );

   always #5 clk = ~clk;

   // Line receiver: mid-bit sampling; also counts idle-high samples between frames
   int          mon_d = 9;
   int          mon_nb = 10;
   bit          mon_en = 1'b1;
   logic [15:0] rxq[$];
   int          gapq[$];

   initial begin : monitor
      int          gap;
      int          nb;
      logic [15:0] bits;
      gap = 0;
      forever begin
         @(negedge clk);
         if (mon_en && rst_n === 1'b1 && tx === 1'b0) begin
            nb   = mon_nb;
            bits = '0;
            repeat (mon_d / 2) @(negedge clk);
            bits[0] = tx;
            for (int k = 1; k < nb; k++) begin
               repeat (mon_d + 1) @(negedge clk);
               bits[4'(k)] = tx;
            end
            rxq.push_back(bits);
            gapq.push_back(gap);
            gap = 0;
         end else begin
            gap++;
         end
      end
   end

   int irq_cnt = 0;
   always @(negedge clk) begin
      if (interrupt === 1'b1) irq_cnt <= irq_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic put(input logic [7:0] b);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic cfg(input logic [1:0] ds, input logic pe, input logic pm, input logic sb);
      data_size   = ds;
      parity_en   = pe;
      parity_mode = pm;
      stop_bits   = sb;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while ((busy !== 1'b0 || empty !== 1'b1) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(n < budget), 32'd1);
   endtask

   task automatic wait_rx(input string tag, input int n, input int budget);
      int c = 0;
      while (rxq.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk(tag, 32'(rxq.size() >= n), 32'd1);
   endtask

   initial begin : stim
      logic [119:0] txw, bw, iw, etx, ebusy, eirq;
      logic [9:0]   pat, tmp;
      logic         e;
      int           base, irq0, acc, first_block, bad;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_fill", 32'(fill_level), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_ready", 32'(tx_ready), 32'd1);
      chk("rst_irq", 32'(interrupt), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 0xAA, divisor 9, 8N1: exact per-clock waveform
      divisor = 16'd9; mon_d = 9; mon_nb = 10; cfg(2'd3, 1'b0, 1'b0, 1'b0);
      irq_threshold = '0;
      base = rxq.size(); irq0 = irq_cnt;
      put(8'hAA);
      chk("aa_fill", 32'(fill_level), 32'd1);
      txw = {1'b1, 119'b0} | ({120{1'b0}}); txw = '0; bw = '0; iw = '0;
      txw = {tx, txw[119:1]}; bw = {busy, bw[119:1]}; iw = {interrupt, iw[119:1]};
      for (int i = 1; i < 120; i++) begin
         @(negedge clk);
         txw = {tx, txw[119:1]}; bw = {busy, bw[119:1]}; iw = {interrupt, iw[119:1]};
      end
      pat = 10'b1101010100;
      etx = '0; ebusy = '0; eirq = '0;
      for (int i = 0; i < 120; i++) begin
         if (i >= 2 && i <= 101) begin
            tmp = pat >> ((i - 2) / 10);
            e = tmp[0];
         end else begin
            e = 1'b1;
         end
         etx   = {e, etx[119:1]};
         ebusy = {(i >= 2 && i <= 101), ebusy[119:1]};
         eirq  = {(i == 101), eirq[119:1]};
      end
      chk_w("aa_tx_wave", 128'(txw), 128'(etx));
      chk_w("aa_busy_wave", 128'(bw), 128'(ebusy));
      chk_w("aa_irq_wave", 128'(iw), 128'(eirq));
      wait_rx("aa_rx_timeout", base + 1, 50);
      if (rxq.size() > base) chk("aa_rx", 32'(rxq[base]), 32'h0354);
      chk("aa_irq_count", 32'(irq_cnt - irq0), 32'd1);
      wait_idle("aa_idle", 200);

      // 20 back-to-back writes of 0..19 into depth 16
      divisor = 16'd3; mon_d = 3; mon_nb = 10;
      irq_threshold = 5'd16;
      base = rxq.size(); irq0 = irq_cnt; acc = 0; first_block = -1;
      for (int i = 0; i < 20; i++) begin
         tx_data  = 8'(i);
         tx_valid = 1'b1;
         if (tx_ready === 1'b1) acc++;
         else if (first_block < 0) first_block = i;
         @(negedge clk);
      end
      tx_valid = 1'b0;
      chk("b2b_accepted", 32'(acc), 32'd17);
      chk("b2b_first_block", 32'(first_block), 32'd17);
      chk("b2b_fill", 32'(fill_level), 32'd16);
      chk("b2b_full", 32'(full), 32'd1);
      chk("b2b_ready", 32'(tx_ready), 32'd0);
      wait_rx("b2b_rx_timeout", base + 17, 17 * 40 + 100);
      for (int k = 0; k < 17; k++) begin
         if (rxq.size() > base + k) begin
            chk($sformatf("b2b_frame%0d", k), 32'(rxq[base + k]), 32'h200 | 32'(k << 1));
            if (k > 0) chk($sformatf("b2b_gap%0d", k), 32'(gapq[base + k]), 32'd2);
         end
      end
      wait_idle("b2b_idle", 200);
      repeat (20) @(negedge clk);
      chk("b2b_count", 32'(rxq.size() - base), 32'd17);
      chk("b2b_irq_count", 32'(irq_cnt - irq0), 32'd17);

      // 8O2 with 0x80, then 5-bit frame of 0x1F
      irq_threshold = '0;
      cfg(2'd3, 1'b1, 1'b1, 1'b1); mon_nb = 12;
      base = rxq.size();
      put(8'h80);
      repeat (6) @(negedge clk);
      data_size = 2'd0; mon_nb = 9;
      put(8'h1F);
      wait_rx("par_rx_timeout", base + 2, 200);
      if (rxq.size() > base + 1) begin
         chk("par_frame_80", 32'(rxq[base]), 32'h0D00);
         chk("par_frame_1f", 32'(rxq[base + 1]), 32'h01BE);
         chk("par_gap", 32'(gapq[base + 1]), 32'd2);
      end
      wait_idle("par_idle", 200);

      // 8N1 -> 7E2 change while a frame is in flight
      cfg(2'd3, 1'b0, 1'b0, 1'b0); mon_nb = 10;
      base = rxq.size();
      put(8'h55);
      repeat (6) @(negedge clk);
      cfg(2'd2, 1'b1, 1'b0, 1'b1); mon_nb = 11;
      put(8'hC3);
      wait_rx("cfg_rx_timeout", base + 2, 200);
      if (rxq.size() > base + 1) begin
         chk("cfg_frame_55", 32'(rxq[base]), 32'h02AA);
         chk("cfg_frame_c3", 32'(rxq[base + 1]), 32'h0786);
      end
      wait_idle("cfg_idle", 200);

      // Clear with a same-edge write while a frame is active
      cfg(2'd3, 1'b0, 1'b0, 1'b0); mon_nb = 10;
      base = rxq.size();
      put(8'h11);
      chk("clr_fill_first", 32'(fill_level), 32'd1);
      put(8'h22);
      chk("clr_fill_wr_pop", 32'(fill_level), 32'd1);
      put(8'h33);
      put(8'h44);
      chk("clr_fill_before", 32'(fill_level), 32'd3);
      buf_clear = 1'b1;
      put(8'h77);
      buf_clear = 1'b0;
      chk("clr_fill_after", 32'(fill_level), 32'd0);
      chk("clr_empty", 32'(empty), 32'd1);
      chk("clr_busy", 32'(busy), 32'd1);
      wait_rx("clr_rx_timeout", base + 1, 100);
      wait_idle("clr_idle", 200);
      repeat (60) @(negedge clk);
      chk("clr_count", 32'(rxq.size() - base), 32'd1);
      if (rxq.size() > base) chk("clr_frame_11", 32'(rxq[base]), 32'h0222);

      // Reset during DATA
      mon_en = 1'b0;
      put(8'h00);
      put(8'hAB);
      put(8'hCD);
      repeat (8) @(negedge clk);
      chk("rstm_tx_low", 32'(tx), 32'd0);
      chk("rstm_busy", 32'(busy), 32'd1);
      chk("rstm_fill", 32'(fill_level), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("rstm_tx", 32'(tx), 32'd1);
      chk("rstm_busy_rst", 32'(busy), 32'd0);
      chk("rstm_fill_rst", 32'(fill_level), 32'd0);
      chk("rstm_empty", 32'(empty), 32'd1);
      chk("rstm_ready", 32'(tx_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      chk("rstm_no_residue", 32'(bad), 32'd0);
      mon_en = 1'b1;

      // Normal operation after reset
      base = rxq.size();
      put(8'h5A);
      wait_rx("post_rx_timeout", base + 1, 100);
      if (rxq.size() > base) chk("post_frame_5a", 32'(rxq[base]), 32'h02B4);
      wait_idle("post_idle", 200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
